// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundles the stall/exception requests into the pipeline
// controller and the stall/flush/statistics signals it returns.
// Signals:
//   stallreq_if/id/ex/mem : per-stage stall requests (to controller)
//   except_req_i          : exception/eret committed in MEM
//   except_pc_i           : handler/EPC target, valid with except_req_i
//   stall                 : per-stage hold vector (bit0=PC .. bit5=WB)
//   flush                 : clear all pipeline registers
//   new_pc                : PC to load while flush=1
//   stall_cycles_o        : saturating count of cycles with stall[0]=1
//   flush_count_o         : wrapping count of flush pulses
//   wdt_timeout_o         : sticky stall-watchdog flag
// Modports: master = pipeline side, slave = controller side.
interface pipe_ctrl_if;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned SC_W    = 32;
  localparam int unsigned FC_W    = 16;

  logic               stallreq_if;
  logic               stallreq_id;
  logic               stallreq_ex;
  logic               stallreq_mem;
  logic               except_req_i;
  logic [PC_W-1:0]    except_pc_i;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [PC_W-1:0]    new_pc;
  logic [SC_W-1:0]    stall_cycles_o;
  logic [FC_W-1:0]    flush_count_o;
  logic               wdt_timeout_o;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output except_req_i, except_pc_i,
    input  stall, flush, new_pc, stall_cycles_o, flush_count_o, wdt_timeout_o
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  except_req_i, except_pc_i,
    output stall, flush, new_pc, stall_cycles_o, flush_count_o, wdt_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller.
// RUN -> (exception) -> FLUSH (1 cycle) -> REFILL (2 unstalled cycles) -> RUN.
// Ports:
//   clk : pipeline clock
//   rst : synchronous active-high reset
//   bus : pipe_ctrl_if.slave (stall requests, exception in; stall, flush,
//         new_pc, statistics, watchdog flag out)
// Configuration:
//   STALL_WDT_EN : when defined, adds a consecutive-stall watchdog that sets
//                  a sticky wdt_timeout_o after 1023 stalled cycles;
//                  otherwise wdt_timeout_o is tied 0.
module pipe_ctrl (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned PC_W    = 32;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned SC_W    = 32;
  localparam int unsigned FC_W    = 16;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_refill_cnt;
  logic [CNT_W-1:0]   w_refill_cnt_nxt;
  logic [PC_W-1:0]    r_new_pc;
  logic [SC_W-1:0]    r_stall_cycles;
  logic [FC_W-1:0]    r_flush_count;
  logic [STALL_W-1:0] w_req_stall;
  logic [STALL_W-1:0] w_stall;
  logic               w_flush;
  logic               w_capture;

  // Stall vector from requests, priority mem > ex > id > if.
  always_comb begin
    w_req_stall = '0;
    if (bus.stallreq_mem)      w_req_stall = 6'b011111;
    else if (bus.stallreq_ex)  w_req_stall = 6'b001111;
    else if (bus.stallreq_id)  w_req_stall = 6'b000111;
    else if (bus.stallreq_if)  w_req_stall = 6'b000111;
  end

  // Next-state and combinational stall/flush outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_refill_cnt_nxt = r_refill_cnt;
    w_stall          = '0;
    w_flush          = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.except_req_i) begin
          w_stall     = '1;
          w_capture   = 1'b1;
          w_state_nxt = FLUSH;
        end else begin
          w_stall = w_req_stall;
        end
      end
      FLUSH: begin
        w_flush          = 1'b1;
        w_refill_cnt_nxt = CNT_W'(2);
        w_state_nxt      = REFILL;
      end
      REFILL: begin
        w_stall = w_req_stall;
        // Refill only progresses in cycles where the PC actually advances.
        if (!w_req_stall[0]) begin
          if (r_refill_cnt <= CNT_W'(1)) begin
            w_refill_cnt_nxt = '0;
            w_state_nxt      = RUN;
          end else begin
            w_refill_cnt_nxt = r_refill_cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt      = RUN;
        w_refill_cnt_nxt = '0;
      end
    endcase
    // Reset masks all control outputs regardless of state or requests.
    if (rst) begin
      w_stall   = '0;
      w_flush   = 1'b0;
      w_capture = 1'b0;
    end
  end

  // State, refill counter, captured PC and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_refill_cnt   <= '0;
      r_new_pc       <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_refill_cnt <= w_refill_cnt_nxt;
      if (w_capture)
        r_new_pc <= bus.except_pc_i;
      if (w_stall[0] && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + SC_W'(1);
      if (w_flush)
        r_flush_count <= r_flush_count + FC_W'(1);
    end
  end

  assign bus.stall          = w_stall;
  assign bus.flush          = w_flush;
  assign bus.new_pc         = r_new_pc;
  assign bus.stall_cycles_o = r_stall_cycles;
  assign bus.flush_count_o  = r_flush_count;

`ifdef STALL_WDT_EN
  localparam int unsigned WDT_W = 10;
  localparam logic [WDT_W-1:0] WDT_MAX = '1;

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_wdt_timeout;

  // Consecutive-stall counter; flag set on the edge the count reaches max.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt_cnt     <= '0;
      r_wdt_timeout <= 1'b0;
    end else if (w_stall[0]) begin
      if (r_wdt_cnt != WDT_MAX)
        r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
      if (r_wdt_cnt >= WDT_MAX - WDT_W'(1))
        r_wdt_timeout <= 1'b1;
    end else begin
      r_wdt_cnt <= '0;
    end
  end

  assign bus.wdt_timeout_o = r_wdt_timeout;
`else
  assign bus.wdt_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl. The stimulus
// process drives one vector per cycle and queues its expected outputs;
// the monitor samples on the falling edge and compares against the queue.
module tb_pipe_ctrl;
`ifdef STALL_WDT_EN
  localparam logic WDT_EXP = 1'b1;
`else
  localparam logic WDT_EXP = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] npc;
    logic [31:0] sc;
    logic [15:0] fc;
    logic        wdt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   total;
  int   bad;
  int   step_id;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req = {mem, ex, id, if}
  task automatic step(input logic r, input logic [3:0] req, input logic exc,
                      input logic [31:0] pc, input logic [5:0] es,
                      input logic ef, input logic [31:0] enp,
                      input logic [31:0] esc, input logic [15:0] efc,
                      input logic ew);
    exp_t e;
    rst              = r;
    bus.stallreq_mem = req[3];
    bus.stallreq_ex  = req[2];
    bus.stallreq_id  = req[1];
    bus.stallreq_if  = req[0];
    bus.except_req_i = exc;
    bus.except_pc_i  = pc;
    e.id    = step_id;
    e.stall = es;
    e.flush = ef;
    e.npc   = enp;
    e.sc    = esc;
    e.fc    = efc;
    e.wdt   = ew;
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (bus.stall !== e.stall || bus.flush !== e.flush ||
          bus.new_pc !== e.npc || bus.stall_cycles_o !== e.sc ||
          bus.flush_count_o !== e.fc || bus.wdt_timeout_o !== e.wdt) begin
        bad++;
        $display("FAIL step%0d: got stall=%b flush=%b new_pc=%h sc=%0d fc=%0d wdt=%b, want stall=%b flush=%b new_pc=%h sc=%0d fc=%0d wdt=%b",
                 e.id, bus.stall, bus.flush, bus.new_pc, bus.stall_cycles_o,
                 bus.flush_count_o, bus.wdt_timeout_o, e.stall, e.flush,
                 e.npc, e.sc, e.fc, e.wdt);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    step_id = 0;
    rst = 1'b1;
    bus.stallreq_mem = 1'b0;
    bus.stallreq_ex  = 1'b0;
    bus.stallreq_id  = 1'b0;
    bus.stallreq_if  = 1'b0;
    bus.except_req_i = 1'b0;
    bus.except_pc_i  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset masks requests and exceptions
    step(1, 4'b1000, 1, 32'h55,  6'b000000, 0, 32'h0, 0, 0, 0);
    // Memory stall for 3 cycles
    step(0, 4'b1000, 0, 32'h0,   6'b011111, 0, 32'h0, 0, 0, 0);
    step(0, 4'b1000, 0, 32'h0,   6'b011111, 0, 32'h0, 1, 0, 0);
    step(0, 4'b1000, 0, 32'h0,   6'b011111, 0, 32'h0, 2, 0, 0);
    step(0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0, 3, 0, 0);
    // Priority patterns
    step(0, 4'b0110, 0, 32'h0,   6'b001111, 0, 32'h0, 3, 0, 0);
    step(0, 4'b0010, 0, 32'h0,   6'b000111, 0, 32'h0, 4, 0, 0);
    step(0, 4'b0001, 0, 32'h0,   6'b000111, 0, 32'h0, 5, 0, 0);
    step(0, 4'b1111, 0, 32'h0,   6'b011111, 0, 32'h0, 6, 0, 0);
    // Exception with mem stall: exception wins
    step(0, 4'b1000, 1, 32'h120, 6'b111111, 0, 32'h0,   7, 0, 0);
    step(0, 4'b1000, 0, 32'h0,   6'b000000, 1, 32'h120, 8, 0, 0);
    step(0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h120, 8, 1, 0);
    step(0, 4'b0000, 1, 32'hABC, 6'b000000, 0, 32'h120, 8, 1, 0);
    // Held exception: one flush, REFILL freezes on stall, re-sampled in RUN
    step(0, 4'b0000, 1, 32'h200, 6'b111111, 0, 32'h120, 8,  1, 0);
    step(0, 4'b0000, 1, 32'h300, 6'b000000, 1, 32'h200, 9,  1, 0);
    step(0, 4'b0000, 1, 32'h300, 6'b000000, 0, 32'h200, 9,  2, 0);
    step(0, 4'b1000, 1, 32'h300, 6'b011111, 0, 32'h200, 9,  2, 0);
    step(0, 4'b0000, 1, 32'h300, 6'b000000, 0, 32'h200, 10, 2, 0);
    step(0, 4'b0000, 1, 32'h300, 6'b111111, 0, 32'h200, 10, 2, 0);
    // Reset during FLUSH
    step(1, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h300, 11, 2, 0);
    step(0, 4'b0000, 1, 32'h44,  6'b111111, 0, 32'h0,   0,  0, 0);
    step(0, 4'b0000, 0, 32'h0,   6'b000000, 1, 32'h44,  1,  0, 0);
    // Reset during REFILL
    step(1, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h44,  1,  1, 0);
    step(0, 4'b1000, 0, 32'h0,   6'b011111, 0, 32'h0,   0,  0, 0);
    step(0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0,   1,  0, 0);
    step(0, 4'b0000, 0, 32'h0,   6'b000000, 0, 32'h0,   1,  0, 0);
    // Long fetch stall for the watchdog
    for (int k = 0; k < 1023; k++)
      step(0, 4'b0001, 0, 32'h0, 6'b000111, 0, 32'h0, 32'(1 + k), 0, 0);
    step(0, 4'b0000, 0, 32'h0, 6'b000000, 0, 32'h0, 1024, 0, WDT_EXP);
    step(0, 4'b0000, 0, 32'h0, 6'b000000, 0, 32'h0, 1024, 0, WDT_EXP);
    step(0, 4'b0001, 0, 32'h0, 6'b000111, 0, 32'h0, 1024, 0, WDT_EXP);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset (RstEnable = 1), sampled on rising edge of clk.
REQ-003 stallreq_if  input  1  fetch-side stall request (instruction bus busy).
REQ-004 stallreq_id  input  1  decode-stage stall request (load-use hazard).
REQ-005 stallreq_ex  input  1  execute-stage stall request (multi-cycle div/madd).
REQ-006 stallreq_mem  input  1  memory-stage stall request (data bus busy).
REQ-007 except_req_i  input  1  exception/eret committed in MEM this cycle.
REQ-008 except_pc_i  input  32  handler or EPC target, valid with except_req_i.
REQ-009 stall  output  6  per-stage hold vector, bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1 = Stop.
REQ-010 flush  output  1  clear all pipeline registers.
REQ-011 new_pc  output  32  PC to load while flush=1.
REQ-012 stall_cycles_o  output  32  count of cycles with stall[0]=1.
REQ-013 flush_count_o  output  16  count of flush pulses.
REQ-014 wdt_timeout_o  output  1  sticky stall-watchdog flag.

Function
REQ-015 FSM states RUN, FLUSH, REFILL; held in a register, next state computed combinationally.
REQ-016 RUN, except_req_i=1: stall=6'b111111, flush=0, except_pc_i captured into new_pc register, next state FLUSH.
REQ-017 RUN, except_req_i=0: stall by priority mem > ex > id > if: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000111, none 6'b000000.
REQ-018 FLUSH lasts exactly one cycle: flush=1, stall=6'b000000, new_pc=captured value; next state REFILL.
REQ-019 REFILL lasts exactly 2 cycles (2-bit down-counter loaded on FLUSH entry); stall per REQ-017 priority; except_req_i ignored; then RUN.
REQ-020 REFILL counter does not decrement in a cycle where stall[0]=1.
REQ-021 flush and stall outputs are combinational from state and inputs; new_pc is registered and holds its value outside FLUSH.
REQ-022 except_req_i and any stallreq_* in the same RUN cycle: exception wins (REQ-016).
REQ-023 stall_cycles_o increments by 1 after each cycle with stall[0]=1; saturates at 32'hFFFFFFFF.
REQ-024 flush_count_o increments by 1 on each FLUSH cycle; wraps 16'hFFFF -> 0.

Reset
REQ-025 rst=1 on an edge: state=RUN, REFILL counter=0, new_pc=0, stall_cycles_o=0, flush_count_o=0, wdt_timeout_o=0, watchdog counter=0.
REQ-026 While rst=1: stall=6'b000000, flush=0, regardless of other inputs.
REQ-027 Reset asserted in FLUSH or REFILL aborts the sequence; no further flush pulse is issued.

Configuration
REQ-028 Macro STALL_WDT_EN defined: a 10-bit counter of consecutive stall[0]=1 cycles, cleared by any cycle with stall[0]=0; when it reaches 1023, wdt_timeout_o is set and stays 1 until reset; the counter saturates at 1023.
REQ-029 STALL_WDT_EN undefined: no watchdog logic; wdt_timeout_o tied 0.

Verification
REQ-030 Reset then stallreq_mem=1 for 3 cycles -> stall=6'b011111 for 3 cycles, stall_cycles_o=3.
REQ-031 stallreq_ex=1 and stallreq_id=1 together -> stall=6'b001111.
REQ-032 except_req_i=1, except_pc_i=32'h00000120 with stallreq_mem=1 -> that cycle stall=6'b111111; next cycle flush=1, new_pc=32'h00000120, stall=0; then 2 REFILL cycles; flush_count_o=1.
REQ-033 except_req_i held high for 4 cycles -> exactly one flush pulse; requests re-sampled only after return to RUN.
REQ-034 rst=1 during FLUSH -> next cycle flush=0, state RUN, all counters 0.
REQ-035 STALL_WDT_EN defined, stallreq_if=1 for 1023 cycles -> wdt_timeout_o=1 after cycle 1023 and stays 1 after stallreq_if drops; undefined -> wdt_timeout_o stays 0.
